// File: rtl/cle_sram_arb.sv
// Label-SRAM arbiter for the component labeling engine: a zero-fill sequencer
// followed by a round-robin/lock arbiter sharing one single-port SRAM.
module cle_sram_arb #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] sram_q,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [AW-1:0]  CNT_MAX = '1;
  localparam logic [LCW-1:0] LCNT_MAX = LCW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, CLEAR, ARB} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           gvld_q, gvld_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;
  logic           hold, pick1, g0, g1;

  // Grant selection: a locked previous winner keeps the port until the
  // other side has waited through LOCK_MAX consecutive grants.
  always_comb begin
    hold  = 1'b0;
    pick1 = 1'b0;
    g0    = 1'b0;
    g1    = 1'b0;
    if (state_q == ARB) begin
      hold = gvld_q && (last_q ? (req1 && lock1) : (req0 && lock0))
             && !((last_q ? req0 : req1) && (lock_cnt_q == LCNT_MAX));
      if (hold)              pick1 = last_q;
      else if (req0 && req1) pick1 = !last_q;
      else                   pick1 = req1;
      g0 = (req0 || req1) && !pick1;
      g1 = (req0 || req1) && pick1;
    end
  end

  always_comb begin
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (state_q == CLEAR) begin
      sram_wen = 1'b0;
      sram_a   = cnt_q;
    end else if (g0) begin
      sram_wen = !we0;
      sram_a   = addr0;
      sram_d   = wdata0;
    end else if (g1) begin
      sram_wen = !we1;
      sram_a   = addr1;
      sram_d   = wdata1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gvld_d     = g0 || g1;
    rvalid0_d  = g0 && !we0;
    rvalid1_d  = g1 && !we1;
    case (state_q)
      IDLE: if (clr_start) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        if (cnt_q == CNT_MAX) state_d = ARB;
        else                  cnt_d   = cnt_q + AW'(1);
      end
      ARB: if (clr_start) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (g0 || g1) begin
      last_d = g1;
      if (g1 == last_q)
        lock_cnt_d = (lock_cnt_q == LCNT_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);
      else
        lock_cnt_d = LCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gvld_q     <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gvld_q     <= gvld_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = sram_q;
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = (state_q == CLEAR) && (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_cle_sram_arb.sv
// Scoreboard bench for cle_sram_arb with a behavioural 1024x8 SRAM model.
module tb_cle_sram_arb;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr_start, clr_busy, clr_done;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, sram_q, sram_d;
  logic [AW-1:0] sram_a;
  logic          sram_wen;

  cle_sram_arb #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .sram_q(sram_q),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'hAA;
    end else if (!sram_wen) begin
      mem[sram_a] <= sram_d;
    end
    sram_q <= mem[sram_a];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected grant one-hots and expected {rvalid one-hot, data}.
  logic [1:0] gq [$];
  logic [9:0] rq [$];
  logic [9:0] re;

  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) chk("unexpected_grant", 32'({gnt1, gnt0}), 32'd0);
      else chk("grant", 32'({gnt1, gnt0}), 32'(gq.pop_front()));
    end
    if (rvalid0 || rvalid1) begin
      if (rq.size() == 0) chk("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      else begin
        re = rq.pop_front();
        chk("rvalid_port", 32'({rvalid1, rvalid0}), 32'(re[9:8]));
        chk("rdata", 32'(rdata), 32'(re[7:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int busy_n, done_at, bad_a, bad_w, bad_g, aa_n, found;

  initial begin
    {clr_start, req0, req1, we0, we1, lock0, lock1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_wen", 32'(sram_wen), 32'd1);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_d", 32'(sram_d), 32'd0);
    tick();
    reset = 1'b1;

    // Requests in IDLE are held off.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 8'h11;
    repeat (3) begin
      @(negedge clk);
      chk("idle_gnt0", 32'(gnt0), 32'd0);
      chk("idle_wen", 32'(sram_wen), 32'd1);
    end
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (clr_busy && sram_a == 10'd300) found = 1;
    end
    chk("reach_300", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_wen", 32'(sram_wen), 32'd1);
    chk("abort_a", 32'(sram_a), 32'd0);
    chk("abort_d", 32'(sram_d), 32'd0);
    chk("abort_busy", 32'(clr_busy), 32'd0);
    chk("abort_done", 32'(clr_done), 32'd0);
    tick();
    tick();
    aa_n = 0;
    for (int i = 300; i < 1024; i++) if (mem[i] == 8'hAA) aa_n++;
    chk("abort_mem0", 32'(mem[0]), 32'd0);
    chk("abort_mem5", 32'(mem[5]), 32'd0);
    chk("abort_mem299", 32'(mem[299]), 32'd0);
    chk("abort_mem300", 32'(mem[300]), 32'hAA);
    chk("abort_kept_words", 32'(aa_n), 32'd724);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_abort_busy", 32'(clr_busy), 32'd0);
      chk("after_abort_gnt0", 32'(gnt0), 32'd0);
    end
    tick();
    req0 = 1'b0;

    // Zero-fill with port 1 waiting to read from word 0 onward.
    preload = 1'b1;
    tick();
    preload = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0;
    gq.push_back(2'b10);
    rq.push_back({2'b10, 8'h00});
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_n = 0; done_at = -1; bad_a = 0; bad_w = 0; bad_g = 0;
    for (int i = 0; i < 1100 && done_at < 0; i++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_n++;
        if (sram_wen !== 1'b0) bad_w++;
        if (sram_a !== 10'(busy_n - 1)) bad_a++;
        if (gnt0 || gnt1) bad_g++;
      end
      if (clr_done) done_at = busy_n;
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd1024);
    chk("clr_done_cycle", 32'(done_at), 32'd1024);
    chk("fill_wen", 32'(bad_w), 32'd0);
    chk("fill_addr", 32'(bad_a), 32'd0);
    chk("fill_no_grant", 32'(bad_g), 32'd0);
    tick();
    @(negedge clk);
    chk("first_grant", 32'({gnt1, gnt0}), 32'd2);
    for (int a = 1; a < 1024; a++) begin
      tick();
      addr1 = 10'(a);
      gq.push_back(2'b10);
      rq.push_back({2'b10, 8'h00});
    end
    tick();

    // Round-robin tie on writes.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h021; wdata0 = 8'h05;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h022; wdata1 = 8'h07;
    gq.push_back(2'b01); gq.push_back(2'b10);
    gq.push_back(2'b01); gq.push_back(2'b10);
    repeat (4) tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reads with one-cycle latency.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h022;
    gq.push_back(2'b01); rq.push_back({2'b01, 8'h07});
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h021;
    gq.push_back(2'b10); rq.push_back({2'b10, 8'h05});
    @(negedge clk);
    chk("rd_gnt1", 32'(gnt1), 32'd1);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid1", 32'(rvalid1), 32'd1);
    chk("rd_rdata", 32'(rdata), 32'h05);
    chk("rd_rvalid0", 32'(rvalid0), 32'd0);
    tick();

    // Lock cap: four grants to port 0, one to port 1, then port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h021; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h022; lock1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gq.push_back(2'b01); rq.push_back({2'b01, 8'h05});
    end
    gq.push_back(2'b10); rq.push_back({2'b10, 8'h07});
    gq.push_back(2'b01); rq.push_back({2'b01, 8'h05});
    repeat (6) tick();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    tick();

    // Read then write of the same word returns the old data.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h030;
    gq.push_back(2'b01); rq.push_back({2'b01, 8'h00});
    tick();
    we0 = 1'b1; wdata0 = 8'h99;
    gq.push_back(2'b01);
    tick();
    we0 = 1'b0;
    gq.push_back(2'b01); rq.push_back({2'b01, 8'h99});
    tick();
    req0 = 1'b0;
    tick();

    // clr_start in ARB still grants this cycle; clear starts next cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h021; clr_start = 1'b1;
    gq.push_back(2'b01); rq.push_back({2'b01, 8'h05});
    @(negedge clk);
    chk("clr_start_gnt0", 32'(gnt0), 32'd1);
    chk("clr_start_busy", 32'(clr_busy), 32'd0);
    tick();
    clr_start = 1'b0;
    @(negedge clk);
    chk("reclear_busy", 32'(clr_busy), 32'd1);
    chk("reclear_gnt0", 32'(gnt0), 32'd0);
    chk("reclear_wen", 32'(sram_wen), 32'd0);
    tick();
    req0 = 1'b0;
    repeat (2) tick();
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("read_queue_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
